// File: rtl/ex_operand_stage.sv
// ex_operand_stage
// ID/EX pipeline register plus operand forwarding and operand selection for
// the execute-stage ALU. It also detects load-use hazards and inserts its own
// bubble.
//
// Ports
//   clk, rst_n          : clock and asynchronous active-low reset
//   stall, flush        : downstream hold / replace contents with a bubble
//   id_*                : decoded instruction fields from ID
//   exmem_*, memwb_*    : writeback forward sources (EX/MEM wins over MEM/WB)
//   alu_a, alu_b        : ALU operands (combinational from registered state)
//   alu_aluc            : ALU operation code
//   ex_valid, ex_rd     : registered valid and destination register
//   ex_reg_write, ex_mem_read, ex_mem_write : registered control flags
//   ex_store_data       : forwarded rt value for stores
//   load_use_stall      : upstream must hold PC and IF/ID this cycle
//
// Flow control: there is no valid/ready pair. The stage accepts the ID
// instruction on every edge unless flush, stall or load_use_stall says
// otherwise. While load_use_stall is high the ID contents must be held
// upstream so they are presented again on the following cycle.
module ex_operand_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [15:0] id_imm,
  input  logic        id_imm_sext,
  input  logic [4:0]  id_shamt,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  input  logic [4:0]  id_rd_addr,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [3:0]  id_aluc,
  input  logic        id_alusrc_imm,
  input  logic        id_shift_var,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_reg_write,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_aluc,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_store_data,
  output logic        load_use_stall
);

  logic        r_valid;
  logic [31:0] r_rs_data;
  logic [31:0] r_rt_data;
  logic [4:0]  r_rs_addr;
  logic [4:0]  r_rt_addr;
  logic [4:0]  r_rd;
  logic [31:0] r_ext_imm;
  logic [4:0]  r_shamt;
  logic [3:0]  r_aluc;
  logic        r_alusrc_imm;
  logic        r_shift_var;
  logic        r_reg_write;
  logic        r_mem_read;
  logic        r_mem_write;

  logic [31:0] w_ext_imm;
  logic [31:0] w_fwd_rs;
  logic [31:0] w_fwd_rt;
  logic        w_is_shift;
  logic [4:0]  w_shift_amt;
  logic        w_load_use;

  assign w_ext_imm = id_imm_sext ? {{16{id_imm[15]}}, id_imm} : {16'b0, id_imm};

  // Forwarding on registered source addresses; register 0 never forwards.
  always_comb begin
    w_fwd_rs = r_rs_data;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == r_rs_addr))
      w_fwd_rs = exmem_result;
    else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == r_rs_addr))
      w_fwd_rs = memwb_result;
  end

  always_comb begin
    w_fwd_rt = r_rt_data;
    if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == r_rt_addr))
      w_fwd_rt = exmem_result;
    else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == r_rt_addr))
      w_fwd_rt = memwb_result;
  end

  // aluc 11xx are the shift ops: A carries the shift amount, B the value.
  assign w_is_shift  = (r_aluc[3:2] == 2'b11);
  assign w_shift_amt = r_shift_var ? w_fwd_rs[4:0] : r_shamt;

  always_comb begin
    alu_a = w_fwd_rs;
    alu_b = r_alusrc_imm ? r_ext_imm : w_fwd_rt;
    if (w_is_shift) begin
      alu_a = {27'b0, w_shift_amt};
      alu_b = w_fwd_rt;
    end
  end

  assign w_load_use = id_valid && r_valid && r_mem_read && (r_rd != 5'd0) &&
                      ((id_uses_rs && (r_rd == id_rs_addr)) ||
                       (id_uses_rt && (r_rd == id_rt_addr)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      if (!rst_n || flush) begin
        r_valid      <= 1'b0;
        r_rs_data    <= 32'd0;
        r_rt_data    <= 32'd0;
        r_rs_addr    <= 5'd0;
        r_rt_addr    <= 5'd0;
        r_rd         <= 5'd0;
        r_ext_imm    <= 32'd0;
        r_shamt      <= 5'd0;
        r_aluc       <= 4'd0;
        r_alusrc_imm <= 1'b0;
        r_shift_var  <= 1'b0;
        r_reg_write  <= 1'b0;
        r_mem_read   <= 1'b0;
        r_mem_write  <= 1'b0;
      end
    end else if (stall) begin
      // Capture the forwarded values so the resolved operands survive the
      // forward sources draining while the stage is held.
      r_rs_data <= w_fwd_rs;
      r_rt_data <= w_fwd_rt;
    end else if (w_load_use) begin
      r_valid      <= 1'b0;
      r_rs_data    <= 32'd0;
      r_rt_data    <= 32'd0;
      r_rs_addr    <= 5'd0;
      r_rt_addr    <= 5'd0;
      r_rd         <= 5'd0;
      r_ext_imm    <= 32'd0;
      r_shamt      <= 5'd0;
      r_aluc       <= 4'd0;
      r_alusrc_imm <= 1'b0;
      r_shift_var  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
    end else begin
      r_valid      <= id_valid;
      r_rs_data    <= id_rs_data;
      r_rt_data    <= id_rt_data;
      r_rs_addr    <= id_rs_addr;
      r_rt_addr    <= id_rt_addr;
      r_rd         <= id_rd_addr;
      r_ext_imm    <= w_ext_imm;
      r_shamt      <= id_shamt;
      r_aluc       <= id_aluc;
      r_alusrc_imm <= id_alusrc_imm;
      r_shift_var  <= id_shift_var;
      r_reg_write  <= id_reg_write;
      r_mem_read   <= id_mem_read;
      r_mem_write  <= id_mem_write;
    end
  end

  assign alu_aluc       = r_aluc;
  assign ex_valid       = r_valid;
  assign ex_reg_write   = r_reg_write;
  assign ex_mem_read    = r_mem_read;
  assign ex_mem_write   = r_mem_write;
  assign ex_rd          = r_rd;
  assign ex_store_data  = w_fwd_rt;
  assign load_use_stall = w_load_use;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Testbench for ex_operand_stage: directed scenarios followed by randomized
// traffic, all checked against a behavioural model of the stage.
module tb_ex_operand_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic        id_imm_sext;
  logic [4:0]  id_shamt, id_rs_addr, id_rt_addr, id_rd_addr;
  logic        id_uses_rs, id_uses_rt;
  logic [3:0]  id_aluc;
  logic        id_alusrc_imm, id_shift_var;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        exmem_reg_write;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_aluc;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_rd;
  logic        load_use_stall;

  ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_imm_sext(id_imm_sext), .id_shamt(id_shamt),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_aluc(id_aluc),
    .id_alusrc_imm(id_alusrc_imm), .id_shift_var(id_shift_var),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_rd(ex_rd), .ex_store_data(ex_store_data),
    .load_use_stall(load_use_stall)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Abstract view of the instruction sitting in EX.
  typedef struct {
    bit      valid;
    longint  rs_val, rt_val, imm_val;
    int      rs_reg, rt_reg, rd_reg, shamt, op;
    bit      use_imm, var_shift, rw, mr, mw;
  } instr_t;

  instr_t m;

  function automatic instr_t empty_instr();
    instr_t e;
    e.valid = 0; e.rs_val = 0; e.rt_val = 0; e.imm_val = 0;
    e.rs_reg = 0; e.rt_reg = 0; e.rd_reg = 0; e.shamt = 0; e.op = 0;
    e.use_imm = 0; e.var_shift = 0; e.rw = 0; e.mr = 0; e.mw = 0;
    return e;
  endfunction

  // Value of register r as seen by EX: youngest in-flight producer wins.
  function automatic longint operand(input int r, input longint stored);
    if (r == 0) return stored;
    if (exmem_reg_write && int'(exmem_rd) == r) return longint'(exmem_result);
    if (memwb_reg_write && int'(memwb_rd) == r) return longint'(memwb_result);
    return stored;
  endfunction

  function automatic longint extend_imm();
    longint v;
    v = longint'(id_imm);
    if (id_imm_sext && v >= 32768) v = v - 65536 + 64'h1_0000_0000;
    return v;
  endfunction

  function automatic bit exp_hazard();
    return id_valid && m.valid && m.mr && m.rd_reg != 0 &&
           ((id_uses_rs && int'(id_rs_addr) == m.rd_reg) ||
            (id_uses_rt && int'(id_rt_addr) == m.rd_reg));
  endfunction

  // ---------------- driver ----------------
  task automatic idle_inputs();
    stall = 0; flush = 0; id_valid = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_imm_sext = 0;
    id_shamt = 0; id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_aluc = 0; id_alusrc_imm = 0;
    id_shift_var = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  // Called just after a falling edge with inputs already applied: checks all
  // outputs against the model, then advances model and DUT one clock edge.
  task automatic cyc();
    longint rs, rt, a, b;
    instr_t nxt;
    #1;
    if (!rst_n) m = empty_instr();
    rs = operand(m.rs_reg, m.rs_val);
    rt = operand(m.rt_reg, m.rt_val);
    if (m.op >= 12) begin
      a = m.var_shift ? (rs % 32) : longint'(m.shamt);
      b = rt;
    end else begin
      a = rs;
      b = m.use_imm ? m.imm_val : rt;
    end
    check("alu_a", alu_a, a[31:0]);
    check("alu_b", alu_b, b[31:0]);
    check("alu_aluc", {28'd0, alu_aluc}, m.op);
    check("ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
    check("ex_reg_write", {31'd0, ex_reg_write}, {31'd0, m.rw});
    check("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m.mr});
    check("ex_mem_write", {31'd0, ex_mem_write}, {31'd0, m.mw});
    check("ex_rd", {27'd0, ex_rd}, m.rd_reg);
    check("ex_store_data", ex_store_data, rt[31:0]);
    check("load_use_stall", {31'd0, load_use_stall}, {31'd0, exp_hazard()});

    nxt = m;
    if (!rst_n || flush) nxt = empty_instr();
    else if (stall) begin
      nxt.rs_val = rs;
      nxt.rt_val = rt;
    end else if (exp_hazard()) nxt = empty_instr();
    else begin
      nxt.valid = id_valid;
      nxt.rs_val = longint'(id_rs_data); nxt.rt_val = longint'(id_rt_data);
      nxt.imm_val = extend_imm();
      nxt.rs_reg = int'(id_rs_addr); nxt.rt_reg = int'(id_rt_addr);
      nxt.rd_reg = int'(id_rd_addr); nxt.shamt = int'(id_shamt);
      nxt.op = int'(id_aluc); nxt.use_imm = id_alusrc_imm;
      nxt.var_shift = id_shift_var; nxt.rw = id_reg_write;
      nxt.mr = id_mem_read; nxt.mw = id_mem_write;
    end
    @(posedge clk);
    m = nxt;
    @(negedge clk);
  endtask

  task automatic put_instr(input logic [4:0] rs_a, input logic [31:0] rs_d,
                           input logic [4:0] rt_a, input logic [31:0] rt_d,
                           input logic [4:0] rd_a, input logic [3:0] op);
    id_valid = 1; id_rs_addr = rs_a; id_rs_data = rs_d;
    id_rt_addr = rt_a; id_rt_data = rt_d; id_rd_addr = rd_a; id_aluc = op;
    id_reg_write = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    m = empty_instr();
    idle_inputs();
    // Reset with nonzero ID inputs: everything reads 0 immediately.
    put_instr(5'd4, 32'hDEAD_BEEF, 5'd6, 32'h1234_5678, 5'd9, 4'hC);
    id_mem_read = 1; id_imm = 16'hFFFF; id_alusrc_imm = 1;
    exmem_reg_write = 1; exmem_rd = 5'd4; exmem_result = 32'h7777_7777;
    #2;
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_store", ex_store_data, 32'd0);
    @(negedge clk); cyc();
    rst_n = 1;
    idle_inputs();

    // First instruction after reset.
    put_instr(5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 4'h0);
    cyc();
    idle_inputs();
    #1;
    check("post_rst_a", alu_a, 32'd5);
    check("post_rst_b", alu_b, 32'd7);
    cyc();

    // Forward priority.
    put_instr(5'd3, 32'h0000_1234, 5'd0, 32'd0, 5'd1, 4'h0);
    cyc();
    idle_inputs();
    exmem_reg_write = 1; exmem_rd = 5'd3; exmem_result = 32'hAAAA_0000;
    memwb_reg_write = 1; memwb_rd = 5'd3; memwb_result = 32'h1111_1111;
    #1; check("fwd_exmem", alu_a, 32'hAAAA_0000);
    exmem_reg_write = 0;
    #1; check("fwd_memwb", alu_a, 32'h1111_1111);
    cyc();
    idle_inputs();
    put_instr(5'd0, 32'h0000_0042, 5'd0, 32'd0, 5'd1, 4'h0);
    cyc();
    idle_inputs();
    exmem_reg_write = 1; exmem_rd = 5'd0; exmem_result = 32'hAAAA_0000;
    memwb_reg_write = 1; memwb_rd = 5'd0; memwb_result = 32'h1111_1111;
    #1; check("fwd_r0", alu_a, 32'h0000_0042);
    cyc();
    idle_inputs();

    // Immediate extension.
    put_instr(5'd1, 32'd0, 5'd2, 32'd9, 5'd3, 4'h0);
    id_alusrc_imm = 1; id_imm = 16'h8000; id_imm_sext = 1;
    cyc();
    #1; check("imm_sext", alu_b, 32'hFFFF_8000);
    id_imm_sext = 0;
    cyc();
    idle_inputs();
    #1; check("imm_zext", alu_b, 32'h0000_8000);
    // sll shamt=4, then sllv with rs=0x123.
    put_instr(5'd1, 32'h0000_0123, 5'd2, 32'h0F, 5'd3, 4'hC);
    id_shamt = 5'd4;
    cyc();
    id_shift_var = 1; id_aluc = 4'hE;
    #1; check("sll_a", alu_a, 32'd4);
    cyc();
    idle_inputs();
    #1; check("sllv_a", alu_a, 32'd3);
    check("sllv_b", alu_b, 32'h0F);
    cyc();

    // Load-use.
    put_instr(5'd1, 32'h100, 5'd0, 32'd0, 5'd8, 4'h0);
    id_mem_read = 1; id_alusrc_imm = 1; id_imm = 16'h4;
    cyc();
    idle_inputs();
    put_instr(5'd8, 32'd0, 5'd9, 32'd2, 5'd10, 4'h0);
    id_uses_rs = 1; id_uses_rt = 1;
    #1; check("lu_stall", {31'd0, load_use_stall}, 32'd1);
    cyc();
    exmem_reg_write = 1; exmem_rd = 5'd8; exmem_result = 32'h104;
    #1; check("lu_bubble", {31'd0, ex_valid}, 32'd0);
    check("lu_released", {31'd0, load_use_stall}, 32'd0);
    cyc();
    idle_inputs();
    memwb_reg_write = 1; memwb_rd = 5'd8; memwb_result = 32'hCAFE_F00D;
    #1; check("lu_fwd", alu_a, 32'hCAFE_F00D);
    check("lu_valid", {31'd0, ex_valid}, 32'd1);
    cyc();
    idle_inputs();

    // Stall retention.
    put_instr(5'd5, 32'd0, 5'd0, 32'd0, 5'd6, 4'h0);
    cyc();
    idle_inputs();
    stall = 1; exmem_reg_write = 1; exmem_rd = 5'd5; exmem_result = 32'h55;
    cyc();
    exmem_reg_write = 0;
    #1; check("stall_hold", alu_a, 32'h55);
    cyc();
    idle_inputs();

    // Flush vs stall.
    put_instr(5'd1, 32'd1, 5'd2, 32'd2, 5'd3, 4'h0);
    cyc();
    idle_inputs();
    flush = 1; stall = 1;
    cyc();
    idle_inputs();
    #1; check("flush_valid", {31'd0, ex_valid}, 32'd0);
    check("flush_rw", {31'd0, ex_reg_write}, 32'd0);
    cyc();

    // Randomized traffic with small register numbers to force hazards.
    for (int i = 0; i < 600; i++) begin
      rst_n          = ($urandom_range(0, 49) != 0);
      stall          = ($urandom_range(0, 4) == 0);
      flush          = ($urandom_range(0, 9) == 0);
      id_valid       = ($urandom_range(0, 5) != 0);
      id_rs_data     = $urandom;
      id_rt_data     = $urandom;
      id_imm         = 16'($urandom);
      id_imm_sext    = 1'($urandom);
      id_shamt       = 5'($urandom);
      id_rs_addr     = 5'($urandom_range(0, 3));
      id_rt_addr     = 5'($urandom_range(0, 3));
      id_rd_addr     = 5'($urandom_range(0, 3));
      id_uses_rs     = 1'($urandom);
      id_uses_rt     = 1'($urandom);
      id_aluc        = 4'($urandom);
      id_alusrc_imm  = 1'($urandom);
      id_shift_var   = 1'($urandom);
      id_reg_write   = 1'($urandom);
      id_mem_read    = ($urandom_range(0, 2) == 0);
      id_mem_write   = 1'($urandom);
      exmem_reg_write = 1'($urandom);
      exmem_rd       = 5'($urandom_range(0, 3));
      exmem_result   = $urandom;
      memwb_reg_write = 1'($urandom);
      memwb_rd       = 5'($urandom_range(0, 3));
      memwb_result   = $urandom;
      cyc();
    end
    rst_n = 1;
    idle_inputs();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register and operand-forwarding stage that feeds the execute-stage ALU directly. It captures decoded instructions, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and selects ALU operands: register, immediate or shift amount. It also detects load-use hazards and inserts a bubble itself. All ALU inputs are presented combinationally from registered state in the same cycle.

## Interface
- No parameters; data width fixed at 32, register address width 5.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: hold stage contents (downstream stall).
- `flush` in 1: replace stage contents with a bubble (branch/exception).
- `id_valid` in 1: ID holds a real instruction.
- `id_rs_data`, `id_rt_data` in 32: register-file read data.
- `id_imm` in 16: raw immediate.
- `id_imm_sext` in 1: 1 = sign-extend imm, 0 = zero-extend.
- `id_shamt` in 5: instruction shamt field.
- `id_rs_addr`, `id_rt_addr`, `id_rd_addr` in 5: source and destination register numbers.
- `id_uses_rs`, `id_uses_rt` in 1: instruction reads rs / rt.
- `id_aluc` in 4: ALU operation code.
- `id_alusrc_imm` in 1: B operand is the extended immediate.
- `id_shift_var` in 1: shift amount comes from rs[4:0] (variable shift), not shamt.
- `id_reg_write`, `id_mem_read`, `id_mem_write` in 1: control flags carried to EX.
- `exmem_reg_write` in 1, `exmem_rd` in 5, `exmem_result` in 32: EX/MEM forward source.
- `memwb_reg_write` in 1, `memwb_rd` in 5, `memwb_result` in 32: MEM/WB forward source.
- `alu_a`, `alu_b` out 32: ALU operands.
- `alu_aluc` out 4: ALU operation code.
- `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_mem_write` out 1: registered control.
- `ex_rd` out 5: registered destination register.
- `ex_store_data` out 32: forwarded rt value, for stores.
- `load_use_stall` out 1: upstream must hold PC and IF/ID this cycle.

## Operation
- Registered state: valid, rs/rt data, rs/rt/rd addresses, extended imm, shamt, aluc, alusrc_imm, shift_var, reg_write, mem_read, mem_write.
- Forwarding per source S in {rs, rt}, evaluated combinationally on registered addresses. Highest priority first:
  - EX/MEM when `exmem_reg_write` and `exmem_rd` != 0 and `exmem_rd` == S_addr.
  - MEM/WB under the same conditions.
  - Otherwise the registered data.
  - Register 0 is never forwarded.
- Shift ops are aluc 1100, 1101, 1110, 1111:
  - `alu_a` = {27'b0, amount}, where amount = fwd_rs[4:0] if shift_var, else shamt.
  - `alu_b` = fwd_rt.
- Non-shift ops:
  - `alu_a` = fwd_rs.
  - `alu_b` = ext_imm if alusrc_imm, else fwd_rt.
  - LUI (aluc 1000/1001) uses alusrc_imm=1; the ALU performs the shift.
- `ex_store_data` = fwd_rt at all times.
- `load_use_stall` (combinational) = id_valid & ex_valid & ex_mem_read & ex_rd != 0 & ((id_uses_rs & ex_rd == id_rs_addr) | (id_uses_rt & ex_rd == id_rt_addr)).
- Edge update, in priority order:
  1. flush: bubble.
  2. stall: hold all fields, except that rs/rt data registers load their current forwarded values, so the resolution survives the sources draining.
  3. load_use_stall: bubble.
  4. Otherwise load all ID inputs.
- A bubble clears valid, reg_write, mem_read and mem_write, sets aluc = 0000, and clears all addresses and data to 0.

## Timing
- Reset (async, while `rst_n` = 0): all registers 0. Hence `ex_valid` = `ex_reg_write` = `ex_mem_read` = `ex_mem_write` = 0, `ex_rd` = 0, `alu_aluc` = 0000, `alu_a` = `alu_b` = `ex_store_data` = 0, and `load_use_stall` = 0.
- Latency: one cycle from ID inputs to registered fields. Operand outputs follow forward inputs in the same cycle, with no extra cycle.
- Reset asserted mid-stall or mid-bubble clears immediately; the first edge after release loads normally.
- flush and stall together: flush wins.
- Stall during load_use_stall: hold wins, and no bubble is inserted.
- A load followed by a dependent instruction:
  - 1-cycle bubble, then the dependent instruction enters EX.
  - It then forwards the load value from MEM/WB.

## Test plan
- Reset: drive `rst_n` = 0 with ID inputs nonzero -> all outputs 0 immediately; after release, `id_aluc` = 0000, rs = 5, rt = 7 -> next cycle `alu_a` = 5, `alu_b` = 7.
- Forward priority: ex rs_addr = 3, `exmem_rd` = 3 (result 0xAAAA0000), `memwb_rd` = 3 (0x11111111) -> `alu_a` = 0xAAAA0000; with `exmem_reg_write` = 0 -> `alu_a` = 0x11111111; with rs_addr = 0 -> no forwarding.
- Immediate and shift: imm 0x8000 with sext=1 -> `alu_b` = 0xFFFF8000, with sext=0 -> 0x00008000; sll shamt = 4 -> `alu_a` = 4; sllv with rs = 0x00000123 -> `alu_a` = 3.
- Load-use: lw rd = 8, then add rs = 8 -> `load_use_stall` = 1 for one cycle, next cycle `ex_valid` = 0, then the add executes with `alu_a` = memwb value.
- Stall retention: stall asserted while `exmem_result` forwards 0x55 to rs, forward source removed next cycle, stall still high -> `alu_a` stays 0x55.
- Flush vs stall: both high -> next cycle `ex_valid` = 0 and `ex_reg_write` = 0.
